fifo_deq_packer: RTL and testbench

//   Consumer at the dequeue end of the team's valid/ready FIFO. Pulls WIDTH-bit entries,

---
 rtl/fifo_deq_packer.sv | 102 ++++++++++
 tb/tb_fifo_deq_packer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_deq_packer.sv
// rtl/fifo_deq_packer.sv - packs LANES consecutive FIFO entries into one wide valid/ready word
module fifo_deq_packer #(
  parameter  int WIDTH = 8,
  parameter  int LANES = 4,
  localparam int CNTW  = $clog2(LANES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   deq_valid,
  output logic                   deq_ready,
  input  logic [WIDTH-1:0]       deq_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*LANES-1:0] out_data,
  output logic [CNTW-1:0]        out_count
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                 state_q;
  logic [CNTW-1:0]        issued_q;
  logic [CNTW-1:0]        captured_q;
  logic                   pend_q;
  logic                   flush_req_q;
  logic                   out_valid_q;
  logic [WIDTH*LANES-1:0] out_data_q;
  logic [CNTW-1:0]        out_count_q;
  logic                   hs;

  // Accept entries only while filling, with lanes left to request and no flush draining
  always_comb begin
    deq_ready = (state_q == FILL) && (issued_q < CNTW'(LANES)) && !flush_req_q;
    hs        = deq_valid && deq_ready;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

  // Packer FSM: FIFO read data is captured one cycle after its handshake (pend_q)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      issued_q    <= '0;
      captured_q  <= '0;
      pend_q      <= 1'b0;
      flush_req_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      case (state_q)
        FILL: begin
          pend_q <= hs;
          if (hs) begin
            issued_q <= issued_q + CNTW'(1);
          end
          if (flush) begin
            flush_req_q <= 1'b1;
          end
          if (pend_q) begin
            for (int i = 0; i < LANES; i++) begin
              if (captured_q == CNTW'(i)) begin
                out_data_q[i*WIDTH +: WIDTH] <= deq_data;
              end
            end
            captured_q <= captured_q + CNTW'(1);
            if (captured_q == CNTW'(LANES - 1)) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              out_count_q <= CNTW'(LANES);
              flush_req_q <= 1'b0;
            end
          end else if (flush_req_q && (captured_q != '0)) begin
            // All issued entries have landed; emit the partial word
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            out_count_q <= captured_q;
            flush_req_q <= 1'b0;
          end else if (flush_req_q && (issued_q == '0)) begin
            // Nothing collected: drop the request without emitting a word
            flush_req_q <= 1'b0;
          end
        end
        HOLD: begin
          pend_q <= 1'b0;
          if (out_ready) begin
            state_q     <= FILL;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            issued_q    <= '0;
            captured_q  <= '0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_deq_packer.sv
// tb/tb_fifo_deq_packer.sv - directed self-checking bench for fifo_deq_packer
module tb_fifo_deq_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        deq_valid;
  logic        deq_ready;
  logic [7:0]  deq_data;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_count;

  fifo_deq_packer #(.WIDTH(8), .LANES(4)) dut (
    .clk(clk), .rst(rst),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  // FIFO model with registered read; output is junk except in the cycle after a handshake
  logic [7:0]  mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          deq_cnt = 0;
  logic        gate = 1'b1;

  assign deq_valid = (wr_ptr != rd_ptr) && gate;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= wr_ptr;
      deq_data <= 8'h00;
    end else if (deq_valid && deq_ready) begin
      deq_data <= mem[rd_ptr % 256];
      rd_ptr   <= rd_ptr + 1;
      deq_cnt  <= deq_cnt + 1;
    end else begin
      deq_data <= 8'hEE;
    end
  end

  // Output monitor: record every accepted word
  logic [31:0] rx_data [0:63];
  logic [2:0]  rx_cnt  [0:63];
  int          rx_n = 0;

  always @(posedge clk) begin
    if (rst && out_valid && out_ready) begin
      rx_data[rx_n % 64] <= out_data;
      rx_cnt[rx_n % 64]  <= out_count;
      rx_n               <= rx_n + 1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 256] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_n < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, rx_n >= n}, 32'd1);
  endtask

  logic [7:0]  exp_b [0:31];
  logic [31:0] prev_data;
  logic        prev_hold;
  int          base;

  initial begin
    // Reset state
    cycles(2);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_count", {29'd0, out_count}, 32'd0);
    chk("rst_deq_ready", {31'd0, deq_ready}, 32'd1);
    rst = 1'b1;
    cycles(1);

    // 1: one full word
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    out_ready = 1'b1;
    wait_rx(1, 20, "t1_timeout");
    cycles(5);
    chk("t1_data", rx_data[0], 32'h44332211);
    chk("t1_count", {29'd0, rx_cnt[0]}, 32'd4);
    chk("t1_deq_cnt", deq_cnt, 32'd4);
    chk("t1_one_word", rx_n, 32'd1);

    // 2: backpressure holds the word and stops dequeues
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    cycles(10);
    chk("t2_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_hold_data", out_data, 32'h04030201);
    chk("t2_hold_count", {29'd0, out_count}, 32'd4);
    chk("t2_deq_ready", {31'd0, deq_ready}, 32'd0);
    chk("t2_fifo_level", wr_ptr - rd_ptr, 32'd4);
    cycles(5);
    chk("t2_stable_data", out_data, 32'h04030201);
    out_ready = 1'b1;
    wait_rx(3, 30, "t2_timeout");
    chk("t2_word1", rx_data[1], 32'h04030201);
    chk("t2_word2", rx_data[2], 32'h08070605);

    // 3: flush of a partial word, then flush with nothing captured
    push(8'hAA); push(8'hBB);
    cycles(6);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    wait_rx(4, 20, "t3_timeout");
    chk("t3_data", rx_data[3], 32'h0000BBAA);
    chk("t3_count", {29'd0, rx_cnt[3]}, 32'd2);
    cycles(2);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    cycles(10);
    chk("t3_empty_flush_no_word", rx_n, 32'd4);
    chk("t3_empty_flush_ready", {31'd0, deq_ready}, 32'd1);

    // 4: flush coincides with the third handshake
    gate = 1'b0;
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    cycles(1);
    base = deq_cnt;
    gate = 1'b1;
    cycles(2);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    chk("t4_three_deq", deq_cnt - base, 32'd3);
    wait_rx(5, 20, "t4_timeout");
    chk("t4_data", rx_data[4], 32'h00CCBBAA);
    chk("t4_count", {29'd0, rx_cnt[4]}, 32'd3);

    // 5: reset after two captures discards the partial word
    push(8'hEE);
    cycles(6);
    chk("t5_pre_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_data", out_data, 32'd0);
    chk("t5_rst_count", {29'd0, out_count}, 32'd0);
    cycles(2);
    rst = 1'b1;
    cycles(1);
    push(8'h5A); push(8'h6B); push(8'h7C); push(8'h8D);
    wait_rx(6, 20, "t5_timeout");
    chk("t5_data", rx_data[5], 32'h8D7C6B5A);
    chk("t5_count", {29'd0, rx_cnt[5]}, 32'd4);

    // 6: random gaps and stalls; order, lane placement and hold stability
    for (int i = 0; i < 32; i++) begin
      exp_b[i] = 8'($urandom);
      push(exp_b[i]);
    end
    prev_hold = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 2000 && rx_n < 14; c++) begin
      @(negedge clk);
      if (prev_hold) begin
        chk("t6_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_hold_data", out_data, prev_data);
      end
      gate      = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
    chk("t6_word_total", rx_n, 32'd14);
    for (int w = 0; w < 8; w++) begin
      chk("t6_word", rx_data[6 + w],
          {exp_b[4*w+3], exp_b[4*w+2], exp_b[4*w+1], exp_b[4*w]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
